pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage LC-3b pipeline (IF, ID, EX, MEM, WB). Every cycle it drives the load and flush strobes of the PC and of the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) from memory handshakes, load-use detection and taken-branch resolution. It tracks wrong-path instruction fetches that are still in flight after a redirect, and it keeps saturating stall/flush performance counters. It sits beside the datapath, and its outputs connect directly to the pipeline registers' load/flush inputs.

---
 rtl/lc3b_types.sv | 10 +
 rtl/load_use_detect.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: register index, data word and the
// pipeline controller's fetch-squash FSM state.
package lc3b_types;

   typedef logic [2:0]  lc3b_reg;
   typedef logic [15:0] lc3b_word;

   typedef enum logic {RUN, SQUASH} lc3b_pctrl_state;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: flags an ID-stage instruction that
// reads the destination of a load still sitting in ID/EX.
module load_use_detect
   import lc3b_types::*;
(
   input  logic    ex_load,
   input  lc3b_reg ex_dest,
   input  lc3b_reg id_sr1,
   input  lc3b_reg id_sr2,
   input  logic    id_uses_sr1,
   input  logic    id_uses_sr2,
   output logic    luse
);

   always_comb begin
      luse = ex_load & ((id_uses_sr1 & (id_sr1 == ex_dest)) |
                        (id_uses_sr2 & (id_sr2 == ex_dest)));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage LC-3b pipeline: drives PC and
// inter-stage load/flush strobes, squashes wrong-path fetches, counts events.
module pipeline_hazard_ctrl
   import lc3b_types::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ifetch_resp,
   output logic             ifetch_req,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   input  lc3b_reg          id_sr1,
   input  lc3b_reg          id_sr2,
   input  logic             id_uses_sr1,
   input  logic             id_uses_sr2,
   input  logic             ex_load,
   input  lc3b_reg          ex_dest,
   input  logic             mem_br_taken,
   output logic             pc_load,
   output logic             if_id_load,
   output logic             id_ex_load,
   output logic             ex_mem_load,
   output logic             mem_wb_load,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   lc3b_pctrl_state  state_q, state_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_events_q, flush_events_d;
   logic             luse, dstall, istall, redirect;

   load_use_detect u_load_use_detect (
      .ex_load     (ex_load),
      .ex_dest     (ex_dest),
      .id_sr1      (id_sr1),
      .id_sr2      (id_sr2),
      .id_uses_sr1 (id_uses_sr1),
      .id_uses_sr2 (id_uses_sr2),
      .luse        (luse)
   );

   always_comb begin
      dstall   = dmem_req & ~dmem_resp;
      istall   = ~ifetch_resp | (state_q == SQUASH);
      redirect = 1'b0;
      state_d  = state_q;

      pc_load      = 1'b1;
      if_id_load   = 1'b1;
      id_ex_load   = 1'b1;
      ex_mem_load  = 1'b1;
      mem_wb_load  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;

      if (dstall) begin
         pc_load     = 1'b0;
         if_id_load  = 1'b0;
         id_ex_load  = 1'b0;
         ex_mem_load = 1'b0;
         mem_wb_load = 1'b0;
      end else if (mem_br_taken) begin
         redirect     = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         // A fetch still outstanding after the redirect returns wrong-path data.
         state_d      = ifetch_resp ? RUN : SQUASH;
      end else begin
         if (luse) begin
            pc_load     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_flush = 1'b1;
         end else if (istall) begin
            pc_load     = 1'b0;
            if_id_flush = 1'b1;
         end
         // Any response in SQUASH is the wrong-path word and is dropped.
         if (state_q == SQUASH && ifetch_resp) state_d = RUN;
      end

      stall_cycles_d = stall_cycles_q;
      if (!pc_load && stall_cycles_q != {CNT_W{1'b1}}) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      flush_events_d = flush_events_q;
      if (redirect && flush_events_q != {CNT_W{1'b1}}) begin
         flush_events_d = flush_events_q + CNT_W'(1);
      end

      ifetch_req = reset_n;
      if (!reset_n) begin
         pc_load      = 1'b0;
         if_id_load   = 1'b0;
         id_ex_load   = 1'b0;
         ex_mem_load  = 1'b0;
         mem_wb_load  = 1'b0;
         if_id_flush  = 1'b0;
         id_ex_flush  = 1'b0;
         ex_mem_flush = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= RUN;
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         state_q        <= state_d;
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;
   import lc3b_types::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ifetch_resp, ifetch_req;
   logic        dmem_req, dmem_resp;
   lc3b_reg     id_sr1, id_sr2, ex_dest;
   logic        id_uses_sr1, id_uses_sr2, ex_load, mem_br_taken;
   logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
   logic        if_id_flush, id_ex_flush, ex_mem_flush;
   logic [15:0] stall_cycles, flush_events;
   logic [7:0]  strobes;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign strobes = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                     if_id_flush, id_ex_flush, ex_mem_flush};

   pipeline_hazard_ctrl #(.CNT_W(16)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .ifetch_resp  (ifetch_resp),
      .ifetch_req   (ifetch_req),
      .dmem_req     (dmem_req),
      .dmem_resp    (dmem_resp),
      .id_sr1       (id_sr1),
      .id_sr2       (id_sr2),
      .id_uses_sr1  (id_uses_sr1),
      .id_uses_sr2  (id_uses_sr2),
      .ex_load      (ex_load),
      .ex_dest      (ex_dest),
      .mem_br_taken (mem_br_taken),
      .pc_load      (pc_load),
      .if_id_load   (if_id_load),
      .id_ex_load   (id_ex_load),
      .ex_mem_load  (ex_mem_load),
      .mem_wb_load  (mem_wb_load),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .ex_mem_flush (ex_mem_flush),
      .stall_cycles (stall_cycles),
      .flush_events (flush_events)
   );

   task automatic set_idle();
      ifetch_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
      id_sr1 = 3'd0; id_sr2 = 3'd0; ex_dest = 3'd0;
      id_uses_sr1 = 1'b0; id_uses_sr2 = 1'b0; ex_load = 1'b0; mem_br_taken = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   task automatic reset_dut();
      set_idle();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      cycle();
   endtask

   task automatic test_reset();
      reset_dut();
      ifetch_resp = 1'b0;
      repeat (4) cycle();
      mem_br_taken = 1'b1;
      cycle();
      mem_br_taken = 1'b0;
      cycle();
      n_cmp++;
      if (stall_cycles !== 16'd5 || dut.state_q !== SQUASH) begin
         n_err++;
         $display("FAIL reset_setup: stall=%0d state=%0d, want stall=5 state=SQUASH",
                  stall_cycles, dut.state_q);
      end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (strobes !== 8'h00 || ifetch_req !== 1'b0 || stall_cycles !== 16'd0 ||
          flush_events !== 16'd0) begin
         n_err++;
         $display("FAIL reset_outputs: strobes=%h req=%b stall=%0d flush=%0d, want all 0",
                  strobes, ifetch_req, stall_cycles, flush_events);
      end
      #2;
      set_idle();
      reset_n = 1'b1;
      #1;
      n_cmp++;
      if (dut.state_q !== RUN || ifetch_req !== 1'b1 || strobes !== 8'hF8) begin
         n_err++;
         $display("FAIL reset_release: state=%0d req=%b strobes=%h, want RUN 1 f8",
                  dut.state_q, ifetch_req, strobes);
      end
      cycle();
   endtask

   task automatic test_load_use();
      reset_dut();
      ex_load = 1'b1; ex_dest = 3'd3; id_uses_sr1 = 1'b1; id_sr1 = 3'd3;
      #1;
      n_cmp++;
      if (strobes !== 8'b00111_010) begin
         n_err++;
         $display("FAIL luse_sr1: strobes=%b want 00111010", strobes);
      end
      cycle();
      n_cmp++;
      if (stall_cycles !== 16'd1) begin
         n_err++;
         $display("FAIL luse_count: stall=%0d want 1", stall_cycles);
      end
      id_uses_sr1 = 1'b0;
      #1;
      n_cmp++;
      if (strobes !== 8'b11111_000) begin
         n_err++;
         $display("FAIL luse_unused: strobes=%b want 11111000", strobes);
      end
      cycle();
      n_cmp++;
      if (stall_cycles !== 16'd1) begin
         n_err++;
         $display("FAIL luse_nocount: stall=%0d want 1", stall_cycles);
      end
      // sr2 match, combined with an instruction-fetch stall: IF/ID held, not flushed
      id_uses_sr2 = 1'b1; id_sr2 = 3'd3; id_sr1 = 3'd5; id_uses_sr1 = 1'b1;
      ifetch_resp = 1'b0;
      #1;
      n_cmp++;
      if (strobes !== 8'b00111_010) begin
         n_err++;
         $display("FAIL luse_sr2_istall: strobes=%b want 00111010", strobes);
      end
      ex_dest = 3'd4;
      #1;
      n_cmp++;
      if (strobes !== 8'b01111_100) begin
         n_err++;
         $display("FAIL istall_only: strobes=%b want 01111100", strobes);
      end
      set_idle();
      cycle();
   endtask

   task automatic test_data_stall();
      reset_dut();
      dmem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (strobes !== 8'h00) begin
            n_err++;
            $display("FAIL dstall_freeze[%0d]: strobes=%b want 00000000", i, strobes);
         end
         cycle();
      end
      dmem_resp = 1'b1;
      #1;
      n_cmp++;
      if (strobes !== 8'b11111_000) begin
         n_err++;
         $display("FAIL dstall_resp: strobes=%b want 11111000", strobes);
      end
      cycle();
      n_cmp++;
      if (stall_cycles !== 16'd3) begin
         n_err++;
         $display("FAIL dstall_count: stall=%0d want 3", stall_cycles);
      end
      set_idle();
   endtask

   task automatic test_squash();
      reset_dut();
      mem_br_taken = 1'b1; ifetch_resp = 1'b0;
      #1;
      n_cmp++;
      if (strobes !== 8'hFF) begin
         n_err++;
         $display("FAIL squash_redirect: strobes=%b want 11111111", strobes);
      end
      cycle();
      n_cmp++;
      if (flush_events !== 16'd1 || dut.state_q !== SQUASH || stall_cycles !== 16'd0) begin
         n_err++;
         $display("FAIL squash_enter: flush=%0d state=%0d stall=%0d, want 1 SQUASH 0",
                  flush_events, dut.state_q, stall_cycles);
      end
      mem_br_taken = 1'b0;
      cycle();
      ifetch_resp = 1'b1;
      #1;
      n_cmp++;
      if (strobes !== 8'b01111_100) begin
         n_err++;
         $display("FAIL squash_discard: strobes=%b want 01111100", strobes);
      end
      cycle();
      n_cmp++;
      if (dut.state_q !== RUN || stall_cycles !== 16'd2) begin
         n_err++;
         $display("FAIL squash_exit: state=%0d stall=%0d, want RUN 2",
                  dut.state_q, stall_cycles);
      end
      n_cmp++;
      if (strobes !== 8'b11111_000) begin
         n_err++;
         $display("FAIL squash_accept: strobes=%b want 11111000", strobes);
      end
      cycle();
   endtask

   task automatic test_branch_in_dstall();
      reset_dut();
      mem_br_taken = 1'b1; dmem_req = 1'b1;
      #1;
      n_cmp++;
      if (strobes !== 8'h00) begin
         n_err++;
         $display("FAIL brdstall_freeze: strobes=%b want 00000000", strobes);
      end
      cycle();
      n_cmp++;
      if (flush_events !== 16'd0 || dut.state_q !== RUN) begin
         n_err++;
         $display("FAIL brdstall_nocount: flush=%0d state=%0d, want 0 RUN",
                  flush_events, dut.state_q);
      end
      dmem_resp = 1'b1;
      #1;
      n_cmp++;
      if (strobes !== 8'hFF) begin
         n_err++;
         $display("FAIL brdstall_redirect: strobes=%b want 11111111", strobes);
      end
      cycle();
      n_cmp++;
      if (flush_events !== 16'd1 || dut.state_q !== RUN) begin
         n_err++;
         $display("FAIL brdstall_count: flush=%0d state=%0d, want 1 RUN",
                  flush_events, dut.state_q);
      end
      set_idle();
   endtask

   task automatic test_saturation();
      reset_dut();
      ifetch_resp = 1'b0;
      repeat (65535 + 3) cycle();
      n_cmp++;
      if (stall_cycles !== 16'hFFFF) begin
         n_err++;
         $display("FAIL stall_saturate: stall=%h want ffff", stall_cycles);
      end
      set_idle();
      cycle();
      n_cmp++;
      if (stall_cycles !== 16'hFFFF) begin
         n_err++;
         $display("FAIL stall_hold: stall=%h want ffff", stall_cycles);
      end
   endtask

   initial begin
      set_idle();
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (strobes !== 8'h00 || ifetch_req !== 1'b0) begin
         n_err++;
         $display("FAIL por_outputs: strobes=%b req=%b, want 0 0", strobes, ifetch_req);
      end
      test_reset();
      test_load_use();
      test_data_stall();
      test_squash();
      test_branch_in_dstall();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
